// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MIPS core's data port.
// Serializes accesses behind a stall handshake and inserts WAIT_STATES
// extra stall cycles per access. Storage is a word-addressed array with
// byte-lane writes.
// Optional build macro: DMEM_ERR_EN adds misalignment/range fault checks
// and the err output. Without it, addresses wrap modulo the array size.
module dmem_responder #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memen,
   input  logic [3:0]  memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
`ifdef DMEM_ERR_EN
   output logic        err,
`endif
   output logic        stall
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  count;
   logic [31:0] adr_q;
   logic [31:0] wd_q;
   logic [3:0]  we_q;

   logic [31:0] acc_adr;
   logic [31:0] acc_wd;
   logic [3:0]  acc_we;
   logic        do_access;
   logic        fault;
   logic [DEPTH_LOG2-1:0] index;

   // Write port pipeline: the array itself carries no reset, so writes are
   // staged through reset-clearable registers and committed one edge later.
   logic                  wr_pend;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [31:0]           wr_data;
   logic [3:0]            wr_be;

   logic [31:0] mem [2**DEPTH_LOG2];

   // The core must freeze while a request is being accepted or waited on.
   always_comb begin
      stall = ((state == IDLE) && memen) || (state == WAIT);
   end

   // Access operands: live inputs for a zero-wait access out of IDLE,
   // otherwise the values captured when the request was accepted.
   always_comb begin
      acc_adr   = adr_q;
      acc_wd    = wd_q;
      acc_we    = we_q;
      do_access = 1'b0;
      if (state == IDLE) begin
         acc_adr   = dataadr;
         acc_wd    = writedata;
         acc_we    = memwrite;
         do_access = memen && (WAIT_STATES == 0);
      end else if (state == WAIT) begin
         do_access = (count == 4'd1);
      end
      index = acc_adr[DEPTH_LOG2+1:2];
   end

`ifdef DMEM_ERR_EN
   // Faults: any non-word-aligned address, or bits above the array range.
   always_comb begin
      fault = (acc_adr[1:0] != 2'b00) || (acc_adr[31:DEPTH_LOG2+2] != '0);
   end
`else
   // Without fault checking the low and high address bits are don't-care.
   logic unused_adr_bits;
   always_comb begin
      fault           = 1'b0;
      unused_adr_bits = ^{acc_adr[31:DEPTH_LOG2+2], acc_adr[1:0]};
   end
`endif

   // Handshake FSM plus registered read data, fault pulse and write staging.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         count    <= 4'd0;
         adr_q    <= 32'h0;
         wd_q     <= 32'h0;
         we_q     <= 4'h0;
         readdata <= 32'h0;
         wr_pend  <= 1'b0;
         wr_idx   <= '0;
         wr_data  <= 32'h0;
         wr_be    <= 4'h0;
`ifdef DMEM_ERR_EN
         err      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (memen) begin
                  adr_q <= dataadr;
                  wd_q  <= writedata;
                  we_q  <= memwrite;
                  count <= 4'(WAIT_STATES);
                  state <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         wr_pend <= do_access && (acc_we != 4'h0) && !fault;
         wr_idx  <= index;
         wr_data <= acc_wd;
         wr_be   <= acc_we;

         if (do_access && (acc_we == 4'h0)) begin
            readdata <= fault ? 32'h0 : mem[index];
         end
`ifdef DMEM_ERR_EN
         err <= do_access && fault;
`endif
      end
   end

   // Commit staged byte-lane writes into the array.
   always_ff @(posedge clk) begin
      if (wr_pend) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: one instance with two wait states and one
// with zero wait states, driven by directed vectors with hand-computed results.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        a_memen;
   logic [3:0]  a_we;
   logic [31:0] a_adr;
   logic [31:0] a_wd;
   logic [31:0] a_rd;
   logic        a_stall;

   logic        b_memen;
   logic [3:0]  b_we;
   logic [31:0] b_adr;
   logic [31:0] b_wd;
   logic [31:0] b_rd;
   logic        b_stall;

`ifdef DMEM_ERR_EN
   logic a_err;
   logic b_err;
`endif

   int total  = 0;
   int passed = 0;

   dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut_a (
      .clk(clk), .rst(rst), .memen(a_memen), .memwrite(a_we),
      .dataadr(a_adr), .writedata(a_wd), .readdata(a_rd),
`ifdef DMEM_ERR_EN
      .err(a_err),
`endif
      .stall(a_stall));

   dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut_b (
      .clk(clk), .rst(rst), .memen(b_memen), .memwrite(b_we),
      .dataadr(b_adr), .writedata(b_wd), .readdata(b_rd),
`ifdef DMEM_ERR_EN
      .err(b_err),
`endif
      .stall(b_stall));

   // Run one access on instance a (sel=0) or b (sel=1); returns the number of
   // stalled cycles and readdata/err sampled in the RESP cycle.
   task automatic access(input bit sel, input logic [3:0] we, input logic [31:0] adr,
                         input logic [31:0] wd, output int stalls,
                         output logic [31:0] rd, output logic er);
      bit done;
      done   = 1'b0;
      stalls = 0;
      rd     = 32'h0;
      er     = 1'b0;
      @(negedge clk);
      if (sel == 1'b0) begin
         a_memen = 1'b1; a_we = we; a_adr = adr; a_wd = wd;
      end else begin
         b_memen = 1'b1; b_we = we; b_adr = adr; b_wd = wd;
      end
      #1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (((sel == 1'b0) ? a_stall : b_stall) === 1'b1) begin
            stalls++;
            @(negedge clk);
            #1;
         end else begin
            done = 1'b1;
         end
      end
      if (!done) begin
         total++;
         $display("[TB] FAIL access_timeout adr=%h: stall still high after 40 cycles, required low", adr);
      end
      rd = (sel == 1'b0) ? a_rd : b_rd;
`ifdef DMEM_ERR_EN
      er = (sel == 1'b0) ? a_err : b_err;
`endif
      a_memen = 1'b0;
      b_memen = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_memen = 1'b0; a_we = 4'h0; a_adr = 32'h0; a_wd = 32'h0;
      b_memen = 1'b0; b_we = 4'h0; b_adr = 32'h0; b_wd = 32'h0;
      #2 rst = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (a_rd !== 32'h0) $display("[TB] FAIL reset_readdata: got %h required %h", a_rd, 32'h0);
      else passed++;
      total++;
      if (a_stall !== 1'b0) $display("[TB] FAIL reset_stall_idle: got %b required 0", a_stall);
      else passed++;
      a_memen = 1'b1;
      #1;
      total++;
      if (a_stall !== 1'b1) $display("[TB] FAIL reset_stall_follows_memen: got %b required 1", a_stall);
      else passed++;
      @(posedge clk);
      #1;
      a_memen = 1'b0;
      #1;
      total++;
      if (a_stall !== 1'b0) $display("[TB] FAIL reset_no_state_change: got stall %b required 0", a_stall);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_wait_states();
      int st; logic [31:0] rd; logic er;
      access(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, st, rd, er);
      total++;
      if (st !== 3) $display("[TB] FAIL ws2_write_stalls: got %0d required 3", st);
      else passed++;
      access(1'b0, 4'h0, 32'h10, 32'h0, st, rd, er);
      total++;
      if (st !== 3) $display("[TB] FAIL ws2_read_stalls: got %0d required 3", st);
      else passed++;
      total++;
      if (rd !== 32'hDEADBEEF) $display("[TB] FAIL ws2_read_data: got %h required %h", rd, 32'hDEADBEEF);
      else passed++;
   endtask

   task automatic test_byte_lanes();
      int st; logic [31:0] rd; logic er;
      access(1'b0, 4'hF, 32'h20, 32'h11223344, st, rd, er);
      total++;
      if (rd !== 32'hDEADBEEF) $display("[TB] FAIL readdata_hold_on_write: got %h required %h", rd, 32'hDEADBEEF);
      else passed++;
      access(1'b0, 4'b0100, 32'h20, 32'h00AA0000, st, rd, er);
      access(1'b0, 4'h0, 32'h20, 32'h0, st, rd, er);
      total++;
      if (rd !== 32'h11AA3344) $display("[TB] FAIL byte_lane_merge: got %h required %h", rd, 32'h11AA3344);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int st; logic [31:0] rd; logic er;
      access(1'b1, 4'hF, 32'h0, 32'hA5A5A5A5, st, rd, er);
      access(1'b1, 4'hF, 32'h4, 32'h5A5A5A5A, st, rd, er);
      access(1'b1, 4'h0, 32'h0, 32'h0, st, rd, er);
      total++;
      if (st !== 1) $display("[TB] FAIL ws0_read0_stalls: got %0d required 1", st);
      else passed++;
      total++;
      if (rd !== 32'hA5A5A5A5) $display("[TB] FAIL ws0_read0_data: got %h required %h", rd, 32'hA5A5A5A5);
      else passed++;
      access(1'b1, 4'h0, 32'h4, 32'h0, st, rd, er);
      total++;
      if (st !== 1) $display("[TB] FAIL ws0_read4_stalls: got %0d required 1", st);
      else passed++;
      total++;
      if (rd !== 32'h5A5A5A5A) $display("[TB] FAIL ws0_read4_data: got %h required %h", rd, 32'h5A5A5A5A);
      else passed++;
   endtask

   task automatic test_reset_midop();
      int st; logic [31:0] rd; logic er;
      access(1'b0, 4'hF, 32'h30, 32'h01234567, st, rd, er);
      access(1'b0, 4'h0, 32'h30, 32'h0, st, rd, er);
      @(negedge clk);
      a_memen = 1'b1; a_we = 4'hF; a_adr = 32'h30; a_wd = 32'hCAFEF00D;
      @(posedge clk);
      #2;
      rst = 1'b0;
      a_memen = 1'b0;
      #1;
      total++;
      if (a_rd !== 32'h0) $display("[TB] FAIL midop_reset_readdata: got %h required %h", a_rd, 32'h0);
      else passed++;
      total++;
      if (a_stall !== 1'b0) $display("[TB] FAIL midop_reset_stall: got %b required 0", a_stall);
      else passed++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      access(1'b0, 4'h0, 32'h30, 32'h0, st, rd, er);
      total++;
      if (rd !== 32'h01234567) $display("[TB] FAIL midop_write_aborted: got %h required %h", rd, 32'h01234567);
      else passed++;
   endtask

   task automatic test_addr_map();
      int st; logic [31:0] rd; logic er;
`ifdef DMEM_ERR_EN
      access(1'b0, 4'hF, 32'h0, 32'h13579BDF, st, rd, er);
      access(1'b0, 4'hF, 32'h1002, 32'h77777777, st, rd, er);
      total++;
      if (er !== 1'b1) $display("[TB] FAIL err_bad_write: got %b required 1", er);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (a_err !== 1'b0) $display("[TB] FAIL err_one_cycle: got %b required 0", a_err);
      else passed++;
      access(1'b0, 4'h0, 32'h0, 32'h0, st, rd, er);
      total++;
      if (rd !== 32'h13579BDF) $display("[TB] FAIL err_write_suppressed: got %h required %h", rd, 32'h13579BDF);
      else passed++;
      access(1'b0, 4'h0, 32'h1000, 32'h0, st, rd, er);
      total++;
      if (er !== 1'b1) $display("[TB] FAIL err_range_read: got %b required 1", er);
      else passed++;
      total++;
      if (rd !== 32'h0) $display("[TB] FAIL err_range_readdata: got %h required %h", rd, 32'h0);
      else passed++;
      access(1'b0, 4'hF, 32'h4, 32'h2468ACE0, st, rd, er);
      access(1'b0, 4'h0, 32'h4, 32'h0, st, rd, er);
      total++;
      if (er !== 1'b0) $display("[TB] FAIL err_good_read: got %b required 0", er);
      else passed++;
      total++;
      if (rd !== 32'h2468ACE0) $display("[TB] FAIL good_read_data: got %h required %h", rd, 32'h2468ACE0);
      else passed++;
`else
      access(1'b0, 4'hF, 32'h1010, 32'h0BADF00D, st, rd, er);
      access(1'b0, 4'h0, 32'h10, 32'h0, st, rd, er);
      total++;
      if (rd !== 32'h0BADF00D) $display("[TB] FAIL wrap_alias: got %h required %h", rd, 32'h0BADF00D);
      else passed++;
      access(1'b0, 4'h0, 32'h13, 32'h0, st, rd, er);
      total++;
      if (rd !== 32'h0BADF00D) $display("[TB] FAIL low_bits_ignored: got %h required %h", rd, 32'h0BADF00D);
      else passed++;
`endif
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_wait_states();
      test_byte_lanes();
      test_back_to_back();
      test_reset_midop();
      test_addr_map();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
